// File: rtl/icb_sram_pipe_if.sv
// ICB command/response bundle between a bus master and the SRAM pipe.
// The master drives the command channel and rsp_ready; the slave drives the rest.
interface icb_sram_pipe_if #(
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              icb_cmd_valid;
   logic              icb_cmd_ready;
   logic [31:0]       icb_cmd_addr;
   logic              icb_cmd_read;
   logic [DATA_W-1:0] icb_cmd_wdata;
   logic [BE_W-1:0]   icb_cmd_wmask;
   logic              icb_rsp_valid;
   logic              icb_rsp_ready;
   logic              icb_rsp_err;
   logic [DATA_W-1:0] icb_rsp_rdata;

   modport master (
      output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
      output icb_rsp_ready,
      input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
   );

   modport slave (
      input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
      input  icb_rsp_ready,
      output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
   );
endinterface

// File: rtl/icb_sram_pipe.sv
// Single-port SRAM behind an ICB slave: one-cycle read latency, byte-masked
// writes, and a 2-entry response skid queue so the command side never stalls early.
module icb_sram_pipe #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4096,
   parameter int RSP_WRITE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   icb_sram_pipe_if.slave  icb
);
   localparam int BE_W  = DATA_W / 8;
   localparam int LSB   = $clog2(BE_W);
   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] rdata;
   } beat_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   logic [31:0]      word;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             acc, beat_new;

   logic             rdy_en_q;
   logic             fl_vld_q, fl_vld_d;
   logic             fl_rd_q, fl_rd_d;
   logic             fl_err_q, fl_err_d;
   beat_t            beat_fl, head;
   beat_t [1:0]      q_q, q_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             pop, push;

   // Any nonzero upper address bit lands past DEPTH because the compare is full width.
   assign word     = icb.icb_cmd_addr >> LSB;
   assign in_range = word < 32'(DEPTH);
   assign idx      = word[IDX_W-1:0];
   assign acc      = icb.icb_cmd_valid & icb.icb_cmd_ready;
   assign beat_new = acc & (icb.icb_cmd_read | (RSP_WRITE != 0));

   always_ff @(posedge clk) begin
      if (acc && in_range) begin
         if (icb.icb_cmd_read) begin
            rdata_q <= mem[idx];
         end else begin
            for (int k = 0; k < BE_W; k++) begin
               if (icb.icb_cmd_wmask[k]) mem[idx][k*8 +: 8] <= icb.icb_cmd_wdata[k*8 +: 8];
            end
         end
      end
   end

   assign fl_vld_d = beat_new;
   assign fl_rd_d  = beat_new & icb.icb_cmd_read & in_range;
   assign fl_err_d = beat_new & ~in_range;

   // In-flight beat is fully qualified by its flags, so it reads as zero when idle.
   always_comb begin
      beat_fl.err   = fl_err_q;
      beat_fl.rdata = fl_rd_q ? rdata_q : '0;
   end

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      pop   = (cnt_q != 2'd0) & icb.icb_rsp_ready;
      push  = fl_vld_q & ~((cnt_q == 2'd0) & icb.icb_rsp_ready);
      if (pop) begin
         q_d[0] = q_q[1];
         cnt_d  = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0) q_d[0] = beat_fl;
         else               q_d[1] = beat_fl;
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q <= 1'b0;
         fl_vld_q <= 1'b0;
         fl_rd_q  <= 1'b0;
         fl_err_q <= 1'b0;
         q_q      <= '0;
         cnt_q    <= 2'd0;
      end else begin
         rdy_en_q <= 1'b1;
         fl_vld_q <= fl_vld_d;
         fl_rd_q  <= fl_rd_d;
         fl_err_q <= fl_err_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head              = (cnt_q != 2'd0) ? q_q[0] : beat_fl;
   assign icb.icb_rsp_valid = (cnt_q != 2'd0) | fl_vld_q;
   assign icb.icb_rsp_err   = head.err;
   assign icb.icb_rsp_rdata = head.rdata;
   // Occupancy < 2 from registers only; rsp_ready never reaches cmd_ready.
   assign icb.icb_cmd_ready = rdy_en_q & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & ~fl_vld_q));
endmodule

// File: tb/tb_icb_sram_pipe.sv
// Random + directed checks of icb_sram_pipe against a beat-queue/memory model;
// instance 1 returns write responses, instance 0 does not.
module tb_icb_sram_pipe;
   localparam int DP = 100;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cv [2], crd [2], rr_s [2];
   logic [31:0] ca [2], cwd [2];
   logic [3:0]  cwm [2];
   logic        crdy [2], rvld [2], rerr [2];
   logic [31:0] rdat [2];

   icb_sram_pipe_if #(.DATA_W(32)) if0 ();
   icb_sram_pipe_if #(.DATA_W(32)) if1 ();

   assign if0.icb_cmd_valid = cv[0];  assign if1.icb_cmd_valid = cv[1];
   assign if0.icb_cmd_read  = crd[0]; assign if1.icb_cmd_read  = crd[1];
   assign if0.icb_cmd_addr  = ca[0];  assign if1.icb_cmd_addr  = ca[1];
   assign if0.icb_cmd_wdata = cwd[0]; assign if1.icb_cmd_wdata = cwd[1];
   assign if0.icb_cmd_wmask = cwm[0]; assign if1.icb_cmd_wmask = cwm[1];
   assign if0.icb_rsp_ready = rr_s[0]; assign if1.icb_rsp_ready = rr_s[1];
   assign crdy[0] = if0.icb_cmd_ready; assign crdy[1] = if1.icb_cmd_ready;
   assign rvld[0] = if0.icb_rsp_valid; assign rvld[1] = if1.icb_rsp_valid;
   assign rerr[0] = if0.icb_rsp_err;   assign rerr[1] = if1.icb_rsp_err;
   assign rdat[0] = if0.icb_rsp_rdata; assign rdat[1] = if1.icb_rsp_rdata;

   icb_sram_pipe #(.DATA_W(32), .DEPTH(DP), .RSP_WRITE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .icb(if0.slave));
   icb_sram_pipe #(.DATA_W(32), .DEPTH(DP), .RSP_WRITE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .icb(if1.slave));

   // Reference: per-instance word memory and a FIFO of outstanding beats.
   logic [31:0] mm [2][DP];
   beat_t q0 [$];
   beat_t q1 [$];
   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One cycle on instance d; the other instance is held idle with rsp_ready low.
   task automatic step(input int d, input bit v, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm, input bit rr, output bit acc);
      beat_t hd, nb;
      int sz;
      logic [31:0] w;
      bit inr;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin cv[i] = 1'b0; rr_s[i] = 1'b0; end
      cv[d] = v; crd[d] = rd; ca[d] = a; cwd[d] = wd; cwm[d] = wm; rr_s[d] = rr;
      #1;
      sz = (d == 0) ? q0.size() : q1.size();
      chk("cmd_ready", crdy[d], sz < 2);
      chk("rsp_valid", rvld[d], sz > 0);
      if (sz > 0) begin
         hd = (d == 0) ? q0[0] : q1[0];
         chk("rsp_err", rerr[d], hd.err);
         chk("rsp_rdata", rdat[d], hd.rdata);
         if (rr) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
      end
      acc = v && (sz < 2);
      if (acc) begin
         w   = a >> 2;
         inr = w < DP;
         if (rd) begin
            nb.err   = !inr;
            nb.rdata = inr ? mm[d][w] : 32'h0;
            if (d == 0) q0.push_back(nb); else q1.push_back(nb);
         end else begin
            if (inr)
               for (int k = 0; k < 4; k++)
                  if (wm[k]) mm[d][w][k*8 +: 8] = wd[k*8 +: 8];
            nb.err   = !inr;
            nb.rdata = 32'h0;
            if (d == 1) q1.push_back(nb);
         end
      end
   endtask

   task automatic issue(input int d, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm, input bit rr);
      bit acc = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) step(d, 1'b1, rd, a, wd, wm, rr, acc);
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain(input int d);
      bit acc;
      for (int n = 0; n < 10; n++) step(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
      chk("drained", (d == 0) ? q0.size() : q1.size(), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin cv[i] = 1'b0; rr_s[i] = 1'b0; end
      q0.delete();
      q1.delete();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_cmd_ready", crdy[i], 64'd0);
         chk("rst_rsp_valid", rvld[i], 64'd0);
         chk("rst_rsp_err", rerr[i], 64'd0);
         chk("rst_rsp_rdata", rdat[i], 64'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("rel_cmd_ready", crdy[0] | crdy[1], 64'd0);
   endtask

   function automatic logic [31:0] raddr();
      case ($urandom % 8)
         0:       return 32'h8000_0000 | $urandom;
         1:       return DP * 4 + ($urandom % 64);
         default: return ($urandom % DP) * 4 + ($urandom % 4);
      endcase
   endfunction

   initial begin
      bit acc;
      for (int i = 0; i < 2; i++) begin
         cv[i] = 0; crd[i] = 0; ca[i] = 0; cwd[i] = 0; cwm[i] = 0; rr_s[i] = 0;
      end
      do_reset();

      // Memory powers up undefined: give both instances known contents first.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DP; i++) issue(d, 1'b0, i * 4, $urandom, 4'hF, 1'b1);
      drain(0);
      drain(1);

      issue(1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
      issue(1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
      issue(1, 1'b0, 32'h20, 32'h1122_3344, 4'hF, 1'b1);
      issue(1, 1'b0, 32'h20, 32'h0000_00AA, 4'h1, 1'b1);
      issue(1, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1);
      drain(1);
      chk("partial_write", mm[1][8], 64'h1122_33AA);

      issue(1, 1'b1, 32'h0, 0, 0, 1'b1);
      issue(1, 1'b1, 32'h4, 0, 0, 1'b1);
      issue(1, 1'b1, 32'h8, 0, 0, 1'b1);
      drain(1);

      step(1, 1'b1, 1'b1, 32'h0, 0, 0, 1'b0, acc);
      step(1, 1'b1, 1'b1, 32'h4, 0, 0, 1'b0, acc);
      step(1, 1'b1, 1'b1, 32'h8, 0, 0, 1'b0, acc);
      step(1, 1'b1, 1'b1, 32'h8, 0, 0, 1'b0, acc);
      issue(1, 1'b1, 32'h8, 0, 0, 1'b1);
      drain(1);

      issue(1, 1'b1, DP * 4, 0, 0, 1'b1);
      issue(1, 1'b1, 32'h8000_0000, 0, 0, 1'b1);
      issue(1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
      issue(1, 1'b0, DP * 4, 32'hFFFF_FFFF, 4'hF, 1'b1);
      issue(1, 1'b1, 32'h0, 0, 0, 1'b1);
      drain(1);

      for (int i = 0; i < 4; i++) issue(0, 1'b0, i * 4, $urandom, 4'hF, 1'b1);
      issue(0, 1'b1, 32'h4, 0, 0, 1'b1);
      drain(0);
      step(0, 1'b1, 1'b1, 32'h8, 0, 0, 1'b0, acc);
      step(0, 1'b1, 1'b1, 32'hC, 0, 0, 1'b0, acc);
      step(0, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, acc);
      do_reset();
      drain(0);
      drain(1);

      for (int n = 0; n < 1500; n++)
         step(($urandom % 4 == 0) ? 0 : 1, ($urandom % 4) != 0, $urandom % 2, raddr(),
              $urandom, 4'($urandom), ($urandom % 3) != 0, acc);
      drain(0);
      drain(1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/icb_sram_pipe.md
ICB_SRAM_PIPE -- requirements
Module: icb_sram_pipe

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; multiple of 8, 32..128.
REQ-002 Parameter DEPTH, default 4096, memory depth in words; any value >= 2, not necessarily a power of 2.
REQ-003 Parameter RSP_WRITE, default 1; 1 = every write returns a response beat, 0 = writes return no response.
REQ-004 Derived constants: BE_W = DATA_W/8, LSB = log2(BE_W), IDX_W = ceil(log2(DEPTH)).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 icb_cmd_valid  in  1  command valid.
REQ-008 icb_cmd_ready  out  1  command ready.
REQ-009 icb_cmd_addr  in  32  byte address.
REQ-010 icb_cmd_read  in  1  1 = read, 0 = write.
REQ-011 icb_cmd_wdata  in  DATA_W  write data.
REQ-012 icb_cmd_wmask  in  BE_W  byte write enables.
REQ-013 icb_rsp_valid  out  1  response valid.
REQ-014 icb_rsp_ready  in  1  response ready.
REQ-015 icb_rsp_err  out  1  response error flag.
REQ-016 icb_rsp_rdata  out  DATA_W  read data.

Function
REQ-017 A command is accepted on a rising edge where icb_cmd_valid and icb_cmd_ready are both 1.
REQ-018 Word index = icb_cmd_addr >> LSB; low LSB address bits are ignored.
REQ-019 Out-of-range: word index >= DEPTH, including any nonzero upper address bits.
REQ-020 Accepted in-range write: byte lane k is written iff wmask[k] = 1; other lanes keep their value.
REQ-021 Out-of-range writes do not modify memory.
REQ-022 Single-port memory, one command per cycle, synchronous read registered once.
REQ-023 A command accepted at edge N creates a response beat that is in flight during cycle N+1.
REQ-024 Beat contents: read in range gives err=0 and rdata = memory word; out-of-range gives err=1 and rdata=0; write gives rdata=0 and err set by the range check.
REQ-025 RSP_WRITE=0: accepted writes create no beat and do not count toward occupancy.
REQ-026 Response path has a 2-entry FIFO queue.
REQ-027 When the queue is empty, the in-flight beat drives icb_rsp_* directly, giving zero-bubble latency of 1 cycle.
REQ-028 When the queue is non-empty, the queue head drives icb_rsp_*.
REQ-029 An in-flight beat not consumed in its cycle is pushed into the queue at the end of that cycle, with contents preserved bit-exact.
REQ-030 icb_rsp_valid = queue non-empty OR beat in flight.
REQ-031 A beat is consumed on an edge where icb_rsp_valid and icb_rsp_ready are both 1.
REQ-032 Beats are delivered strictly in command order.
REQ-033 Occupancy = queue count + in-flight flag, range 0..2.
REQ-034 icb_cmd_ready = (occupancy < 2), registered-derived, with no combinational path from icb_rsp_ready.
REQ-035 If icb_rsp_ready is held 1 and icb_cmd_valid is held 1, one command is accepted per cycle with one beat per cycle, i.e. 100% throughput.
REQ-036 Simultaneous push and pop in one cycle leaves the queue count unchanged, with correct order.
REQ-037 The queue never overflows; a push to a full queue is unreachable by construction.
REQ-038 A read issued the cycle after a write to the same address returns the newly written data.
REQ-039 rsp_* values are held stable while icb_rsp_valid=1 and icb_rsp_ready=0.

Reset
REQ-040 rst_n low gives icb_cmd_ready=0 (asserted 1 from the first clk edge after release), icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, empty queue and in-flight flag=0.
REQ-041 Reset mid-operation discards all queued and in-flight beats; memory contents are not reset and are undefined after power-up.

Verification
REQ-042 Write 0xDEADBEEF to addr 0x10 with wmask 0xF, then read 0x10 -> write beat rdata=0 err=0, then read beat 0xDEADBEEF at 1-cycle latency.
REQ-043 Write 0x000000AA with wmask 0x1 over existing 0x11223344, then read -> 0x112233AA.
REQ-044 Back-to-back reads of 0x0, 0x4, 0x8 with rsp_ready=1 -> cmd_ready stays 1 and three consecutive beats arrive in order.
REQ-045 Hold rsp_ready=0 while issuing 3 reads -> 2 accepted, then cmd_ready=0; release rsp_ready -> beats arrive in order and the third command is then accepted.
REQ-046 Read addr DEPTH*BE_W and addr 0x8000_0000 -> err=1, rdata=0; a write to the same address leaves word 0 unchanged.
REQ-047 RSP_WRITE=0: 4 writes then 1 read -> exactly 1 beat; assert rst_n low with 2 beats pending -> rsp_valid=0 after reset.
